uart_fifo_core: RTL and testbench
=================================

# uart_fifo_core

Parametrised second-generation UART core with an internal fractional-free baud generator, runtime frame format, a majority-vote receiver and a receive FIFO with per-entry error flags. It replaces the fixed 16x core behind the Tiny Tapeout wrapper. It adds a valid/ready transmit handshake, break detection, an overrun flag and buffered receive data. All logic runs in one clock domain; `rx_in` is the only asynchronous input.

## Interface
- OSR, 16: oversampling ticks per bit; even, 8..32.
- DIV_W, 12: width of `baud_div`.
- FIFO_DEPTH, 4: RX FIFO entries; power of two, 2..16.
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- baud_div  in  DIV_W  tick period minus one. One tick every `baud_div+1` clocks.
- data_len  in  2  data bits minus 5 (0=5 … 3=8).
- parity_en  in  1  parity bit present.
- parity_odd  in  1  1=odd parity, 0=even parity.
- stop2  in  1  TX sends two stop bits.
- tx_data  in  8  TX byte; bits above data_len are ignored.
- tx_valid  in  1  TX request.
- tx_ready  out  1  high while TX is IDLE; a transfer occurs when `tx_valid && tx_ready`.
- tx_out  out  1  serial output; idle high.
- tx_busy  out  1  TX state is not IDLE.
- rx_in  in  1  serial input, asynchronous.
- rx_data  out  8  FIFO head data, right-justified, upper bits zero.
- rx_parity_err, rx_frame_err, rx_break  out  1 each  flags of the FIFO head entry.
- rx_valid  out  1  FIFO is not empty.
- rx_pop  in  1  pops the head when `rx_valid` is high; ignored when empty.
- rx_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- rx_overrun  out  1  sticky flag: a frame was dropped.
- overrun_clr  in  1  clears `rx_overrun`.

## Operation
- **Baud generator**
  - A free-running counter runs 0..`baud_div`; `tick` pulses for one clock when the counter equals `baud_div`, then the counter returns to 0.
  - `baud_div=0` gives a tick every clock.
  - The generator is shared by TX and RX. One bit lasts OSR ticks.
- **TX FSM: IDLE→START→DATA→PARITY→STOP→IDLE**
  - On handshake, latch the data and the whole config. Parity = XOR of the `data_len+5` data bits, inverted if `parity_odd`.
  - START drives 0. DATA drives LSB first for `data_len+5` bits. PARITY is skipped if `!parity_en`. STOP drives 1 for 1 or 2 bits.
  - Each state holds for exactly OSR ticks. The tick count starts at the first tick on or after the clock following the handshake.
  - Config changes mid-frame have no effect.
- **RX front end**
  - 2-FF synchroniser, reset value 1.
  - Each bit sample is the majority vote of the synced line at ticks OSR/2-1, OSR/2 and OSR/2+1 of that bit.
- **RX FSM: IDLE→START→DATA→PARITY→STOP→IDLE**
  - IDLE: a synced low starts the bit tick counter at 0.
  - START: if the vote at mid-bit is 1, this is a glitch; return to IDLE with nothing written.
  - Config is latched at start detection.
  - PARITY (if enabled): a mismatch sets `perr`.
  - STOP: a vote of 0 sets `ferr`. Break = `ferr` and all data bits 0 and the parity bit (if present) 0.
  - Only the first stop bit is checked. After the STOP sample (tick OSR/2+1), write {break, ferr, perr, data} and return to IDLE immediately.
- **RX FIFO** (first-word fall-through)
  - Push when not full, or when full with `rx_pop` in the same cycle (simultaneous push and pop leaves the count unchanged).
  - Push when full without a pop: the frame is dropped and `rx_overrun` is set.
  - Pointers wrap modulo FIFO_DEPTH.
  - `overrun_clr` together with a new overrun in the same cycle: `rx_overrun` stays 1.
- **Reset mid-frame**: both FSMs go to IDLE, the FIFO empties, and the frame in progress is lost.

## Timing
- Reset values:
  - `tx_out=1`, `tx_busy=0`, `tx_ready=1`
  - `rx_valid=0`, `rx_count=0`, `rx_data=0`, all flags 0, `rx_overrun=0`
  - baud counter 0, synchroniser 1.
- TX: `tx_ready` falls, and `tx_busy` and `tx_out=0` assert, one clock after the handshake.
- TX frame: `(1 + N + P + S)·OSR` ticks. `tx_ready` rises on the clock after the last stop tick, so back-to-back frames have no idle gap.
- RX latency: the FIFO write is visible (`rx_valid` and `rx_count` updated) one clock after the stop-bit decision tick. Synchroniser delay is 2 clocks.
- `rx_pop`: the head advances on the next clock. `rx_data` and the flags are registered from the FIFO memory, with no combinational path from `rx_pop`.
- `tx_out`, `tx_busy`, `rx_valid` and `rx_overrun` are direct register outputs.

## Test plan
- **Loopback 8N1.** OSR=16, `baud_div=3`, loop `tx_out`→`rx_in`, send 0xA5.
  - TX frame lasts 640 clocks.
  - `rx_data=0xA5`, all flags 0, `rx_count=1`.
- **8E1 and 7O2 formats.** Send 0x55 with even parity: parity bit 0.
  - Send 0x7F with `data_len=2`, `parity_odd`, `stop2`: parity bit 0 and frame 11 bits long.
  - RX returns 0x55 and 0x7F clean.
- **Errors.** Drive a frame with a wrong parity bit → `rx_parity_err=1`.
  - Drive a frame with stop=0 → `rx_frame_err=1`.
  - Drive 0x00 with stop=0 → `rx_break=1`.
- **Glitch rejection.** Pulse `rx_in` low for 3 ticks: no FIFO write, RX returns to IDLE.
  - Force a single-tick inversion at mid-bit: the data is still correct because of the majority vote.
- **Overrun.** FIFO_DEPTH=4, receive 5 frames without popping.
  - `rx_count=4`, `rx_overrun=1`, first 4 bytes are preserved.
  - Pop together with a push when full: count stays 4.
  - `overrun_clr` clears the flag.
- **Reset mid-operation.** Assert `rst_n` low during TX DATA and RX DATA.
  - Outputs take their reset values immediately. A subsequent clean frame is received correctly.

Source files
------------

// File: rtl/uart_fifo_core.sv
// uart_fifo_core: oversampled UART with runtime frame format, majority-vote receiver and flagged RX FIFO
module uart_fifo_core #(
  parameter int OSR = 16,
  parameter int DIV_W = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [DIV_W-1:0]                baud_div,
  input  logic [1:0]                      data_len,
  input  logic                            parity_en,
  input  logic                            parity_odd,
  input  logic                            stop2,
  input  logic [7:0]                      tx_data,
  input  logic                            tx_valid,
  output logic                            tx_ready,
  output logic                            tx_out,
  output logic                            tx_busy,
  input  logic                            rx_in,
  output logic [7:0]                      rx_data,
  output logic                            rx_parity_err,
  output logic                            rx_frame_err,
  output logic                            rx_break,
  output logic                            rx_valid,
  input  logic                            rx_pop,
  output logic [$clog2(FIFO_DEPTH):0]     rx_count,
  output logic                            rx_overrun,
  input  logic                            overrun_clr
);
  localparam int TW = $clog2(OSR);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int H = OSR / 2;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  logic [DIV_W-1:0] bcnt;
  logic tick;
  // >= rather than == so a smaller divider written mid-count takes effect at once
  assign tick = bcnt >= baud_div;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) bcnt <= '0;
    else bcnt <= tick ? '0 : bcnt + 1'b1;
  state_t ts;
  logic [TW-1:0] ttc;
  logic [7:0] tsh;
  logic [2:0] tbc;
  logic [1:0] tlen;
  logic tpe, tpar, ts2, tsec, tlast;
  assign tlast = tick && ttc == TW'(OSR - 1);
  assign tx_ready = !tx_busy;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ts <= IDLE;
      ttc <= '0;
      tsh <= '0;
      tbc <= '0;
      tlen <= '0;
      tpe <= 1'b0;
      tpar <= 1'b0;
      ts2 <= 1'b0;
      tsec <= 1'b0;
      tx_out <= 1'b1;
      tx_busy <= 1'b0;
    end else begin
      if (ts != IDLE && tick) ttc <= tlast ? '0 : ttc + 1'b1;
      case (ts)
        IDLE: if (tx_valid) begin
          ts <= START;
          ttc <= '0;
          tbc <= '0;
          tsec <= 1'b0;
          tsh <= tx_data;
          tlen <= data_len;
          tpe <= parity_en;
          ts2 <= stop2;
          tpar <= ^(tx_data & (8'hff >> (2'd3 - data_len))) ^ parity_odd;
          tx_out <= 1'b0;
          tx_busy <= 1'b1;
        end
        START: if (tlast) begin
          ts <= DATA;
          tx_out <= tsh[0];
          tsh <= tsh >> 1;
        end
        DATA: if (tlast) begin
          if (tbc == {1'b0, tlen} + 3'd4) begin
            ts <= tpe ? PARITY : STOP;
            tx_out <= tpe ? tpar : 1'b1;
          end else begin
            tbc <= tbc + 1'b1;
            tx_out <= tsh[0];
            tsh <= tsh >> 1;
          end
        end
        PARITY: if (tlast) begin
          ts <= STOP;
          tx_out <= 1'b1;
        end
        STOP: if (tlast) begin
          if (ts2 && !tsec) tsec <= 1'b1;
          else begin
            ts <= IDLE;
            tx_busy <= 1'b0;
          end
        end
        default: ts <= IDLE;
      endcase
    end
  state_t rs;
  logic s1, s2, v0, v1, rpe, rodd, rpb, vote, dec, rlast, push, ferr, perr, brk;
  logic [TW-1:0] rtc;
  logic [2:0] rbc;
  logic [1:0] rlen;
  logic [7:0] rsh;
  logic [10:0] wdata;
  assign vote = (v0 & v1) | (v0 & s2) | (v1 & s2);
  assign dec = tick && rtc == TW'(H + 1);
  assign rlast = tick && rtc == TW'(OSR - 1);
  assign push = rs == STOP && dec;
  assign ferr = !vote;
  assign perr = rpe && (rpb != (^rsh ^ rodd));
  assign brk = ferr && rsh == 8'd0 && !(rpe && rpb);
  assign wdata = {brk, ferr, perr, rsh};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      rs <= IDLE;
      rtc <= '0;
      rbc <= '0;
      rlen <= '0;
      rpe <= 1'b0;
      rodd <= 1'b0;
      rpb <= 1'b0;
      v0 <= 1'b0;
      v1 <= 1'b0;
      rsh <= '0;
    end else begin
      s1 <= rx_in;
      s2 <= s1;
      if (rs != IDLE && tick) begin
        rtc <= rlast ? '0 : rtc + 1'b1;
        if (rtc == TW'(H - 1)) v0 <= s2;
        if (rtc == TW'(H)) v1 <= s2;
      end
      case (rs)
        IDLE: if (!s2) begin
          rs <= START;
          rtc <= '0;
          rbc <= '0;
          rsh <= '0;
          rpb <= 1'b0;
          rlen <= data_len;
          rpe <= parity_en;
          rodd <= parity_odd;
        end
        START: if (dec && vote) rs <= IDLE;
               else if (rlast) rs <= DATA;
        DATA: begin
          if (dec) rsh[rbc] <= vote;
          if (rlast) begin
            if (rbc == {1'b0, rlen} + 3'd4) rs <= rpe ? PARITY : STOP;
            else rbc <= rbc + 1'b1;
          end
        end
        PARITY: begin
          if (dec) rpb <= vote;
          if (rlast) rs <= STOP;
        end
        STOP: if (dec) rs <= IDLE;
        default: rs <= IDLE;
      endcase
    end
  logic [10:0] mem [FIFO_DEPTH];
  logic [10:0] head;
  logic [AW-1:0] wp, rp, nrp;
  logic [CW-1:0] cnt, ncnt;
  logic full, pop, wr;
  assign full = cnt == CW'(FIFO_DEPTH);
  assign pop = rx_pop && cnt != '0;
  assign wr = push && (!full || pop);
  assign nrp = rp + AW'(pop);
  assign ncnt = cnt + CW'(wr) - CW'(pop);
  assign rx_count = cnt;
  assign {rx_break, rx_frame_err, rx_parity_err, rx_data} = head;
  always_ff @(posedge clk)
    if (wr) mem[wp] <= wdata;
  // head is re-registered every clock; bypass covers a write landing on the next read slot
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      head <= '0;
      rx_valid <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      rp <= nrp;
      cnt <= ncnt;
      rx_valid <= ncnt != '0;
      head <= ncnt == '0 ? '0 : (wr && nrp == wp) ? wdata : mem[nrp];
      rx_overrun <= (rx_overrun && !overrun_clr) || (push && full && !pop);
    end
endmodule

// File: tb/tb_uart_fifo_core.sv
// tb_uart_fifo_core: scoreboard bench for loopback, formats, errors, glitches, overrun and reset
module tb_uart_fifo_core;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [11:0] baud_div;
  logic [1:0] data_len;
  logic parity_en, parity_odd, stop2, tx_valid, tx_ready, tx_out, tx_busy, rx_in;
  logic [7:0] tx_data, rx_data;
  logic rx_parity_err, rx_frame_err, rx_break, rx_valid, rx_pop, rx_overrun, overrun_clr;
  logic [2:0] rx_count;
  logic loop, rx_drv;
  int n_chk = 0, n_fail = 0, cyc = 0, pop_at = -1, bd_cur = 0;
  bit pop_en = 0;
  logic [10:0] exp_q[$];
  uart_fifo_core #(.OSR(16), .DIV_W(12), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .data_len(data_len),
    .parity_en(parity_en), .parity_odd(parity_odd), .stop2(stop2),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_out(tx_out),
    .tx_busy(tx_busy), .rx_in(rx_in), .rx_data(rx_data), .rx_parity_err(rx_parity_err),
    .rx_frame_err(rx_frame_err), .rx_break(rx_break), .rx_valid(rx_valid),
    .rx_pop(rx_pop), .rx_count(rx_count), .rx_overrun(rx_overrun), .overrun_clr(overrun_clr)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign rx_in = loop ? tx_out : rx_drv;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  initial begin
    rx_pop = 1'b0;
    forever begin
      @(negedge clk);
      rx_pop = 1'b0;
      if (rx_valid && (pop_en || cyc == pop_at)) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL rx_unexpected: got %0h expected no entry", {rx_break, rx_frame_err, rx_parity_err, rx_data});
        end else check("rx_entry", {rx_break, rx_frame_err, rx_parity_err, rx_data}, exp_q.pop_front());
        rx_pop = 1'b1;
      end
    end
  end
  task automatic cfg(input int bd, input logic [1:0] len, input logic pe, input logic po, input logic s2);
    baud_div = bd[11:0];
    bd_cur = bd;
    data_len = len;
    parity_en = pe;
    parity_odd = po;
    stop2 = s2;
  endtask
  task automatic send_tx(input logic [7:0] d, input logic [11:0] exp_bits, input int n);
    int c, idx, b;
    logic [11:0] bits;
    b = bd_cur + 1;
    bits = '1;
    idx = 0;
    c = 1;
    @(negedge clk);
    check("tx_ready_idle", tx_ready, 1);
    tx_data = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("tx_start", {tx_ready, tx_busy, tx_out}, 3'b010);
    while (!tx_ready && c < 20 * 16 * b) begin
      if (c >= 8 * b && (c - 8 * b) % (16 * b) == 0 && idx < n) begin
        bits[idx] = tx_out;
        idx++;
      end
      @(negedge clk);
      c++;
    end
    check("tx_bits", bits, exp_bits);
    n_chk++;
    if (c - 1 < 16 * n * b - b + 1 || c - 1 > 16 * n * b) begin
      n_fail++;
      $display("FAIL tx_frame_len: got %0d clocks expected %0d..%0d", c - 1, 16 * n * b - b + 1, 16 * n * b);
    end
  endtask
  task automatic drive_frame(input logic [11:0] bits, input int n, input int gl_bit, input int pop_off);
    for (int i = 0; i < n; i++)
      for (int c = 0; c < 16 * (bd_cur + 1); c++) begin
        @(negedge clk);
        if (i == 0 && c == 0 && pop_off > 0) pop_at = cyc + pop_off;
        rx_drv = bits[i] ^ (i == gl_bit && c == 9);
      end
    @(negedge clk);
    rx_drv = 1'b1;
    repeat (32) @(negedge clk);
  endtask
  task automatic wait_drain(input int bound);
    int c = 0;
    while (exp_q.size() != 0 && c < bound) begin
      @(negedge clk);
      c++;
    end
    check("scoreboard_drain", exp_q.size(), 0);
    exp_q.delete();
  endtask
  task automatic check_reset_vals();
    check("rst_tx", {tx_out, tx_busy, tx_ready}, 3'b101);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_count", rx_count, 0);
    check("rst_rx_head", {rx_break, rx_frame_err, rx_parity_err, rx_data}, 0);
    check("rst_overrun", rx_overrun, 0);
  endtask
  initial begin
    tx_valid = 1'b0;
    tx_data = 8'h00;
    rx_drv = 1'b1;
    loop = 1'b1;
    overrun_clr = 1'b0;
    cfg(3, 2'd3, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    exp_q.push_back(11'h0A5);
    send_tx(8'hA5, {2'b11, 1'b1, 8'hA5, 1'b0}, 10);
    repeat (4) @(negedge clk);
    check("loop_rx_count", rx_count, 1);
    check("loop_rx_valid", rx_valid, 1);
    pop_en = 1;
    wait_drain(100);
    cfg(3, 2'd3, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(11'h055);
    send_tx(8'h55, {1'b1, 1'b1, 1'b0, 8'h55, 1'b0}, 11);
    wait_drain(100);
    cfg(3, 2'd2, 1'b1, 1'b1, 1'b1);
    exp_q.push_back(11'h07F);
    send_tx(8'hFF, {1'b1, 1'b1, 1'b1, 1'b0, 7'h7F, 1'b0}, 11);
    wait_drain(100);
    loop = 1'b0;
    cfg(0, 2'd3, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(11'h155);
    drive_frame({1'b1, 1'b1, 1'b1, 8'h55, 1'b0}, 11, -1, 0);
    cfg(0, 2'd3, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(11'h20F);
    drive_frame({2'b11, 1'b0, 8'h0F, 1'b0}, 10, -1, 0);
    exp_q.push_back(11'h600);
    drive_frame({2'b11, 1'b0, 8'h00, 1'b0}, 10, -1, 0);
    wait_drain(100);
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (3) @(negedge clk);
    rx_drv = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_count", rx_count, 0);
    check("glitch_valid", rx_valid, 0);
    exp_q.push_back(11'h03C);
    drive_frame({2'b11, 1'b1, 8'h3C, 1'b0}, 10, 3, 0);
    wait_drain(100);
    pop_en = 0;
    for (int i = 1; i <= 5; i++) begin
      logic [7:0] d;
      d = 8'(i * 17);
      if (i < 5) exp_q.push_back({3'b000, d});
      drive_frame({2'b11, 1'b1, d, 1'b0}, 10, -1, 0);
    end
    check("ovr_count", rx_count, 4);
    check("ovr_flag", rx_overrun, 1);
    check("ovr_head", rx_data, 8'h11);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    check("ovr_clear", rx_overrun, 0);
    exp_q.push_back(11'h066);
    drive_frame({2'b11, 1'b1, 8'h66, 1'b0}, 10, -1, 156);
    check("full_pushpop_count", rx_count, 4);
    check("full_pushpop_no_ovr", rx_overrun, 0);
    pop_en = 1;
    wait_drain(100);
    loop = 1'b1;
    pop_en = 0;
    cfg(3, 2'd3, 1'b0, 1'b0, 1'b0);
    send_tx(8'h5A, {2'b11, 1'b1, 8'h5A, 1'b0}, 10);
    repeat (4) @(negedge clk);
    check("pre_rst_count", rx_count, 1);
    tx_data = 8'hA5;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (300) @(negedge clk);
    check("pre_rst_busy", tx_busy, 1);
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    pop_en = 1;
    repeat (4) @(negedge clk);
    exp_q.push_back(11'h0C3);
    send_tx(8'hC3, {2'b11, 1'b1, 8'hC3, 1'b0}, 10);
    wait_drain(100);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
